uart_pos_deframer: RTL
======================

Name: uart_pos_deframer

Overview:
Receive-side packet parser between uart_rx and the game logic. It consumes the byte stream (rx_done_tick/dout) and recognises 6-byte tank-position frames. It validates each frame with an XOR checksum and an inter-byte timeout. It publishes X/Y positions atomically, replacing direct byte-register capture.

Parameters:
HEADER, 8'hA5, start-of-frame byte.
TIMEOUT_CYC, 2_000_000, max clk cycles between consecutive bytes of one frame (20 ms at 100 MHz).
TO_BIT, 21, width of the timeout counter; must satisfy 2^TO_BIT > TIMEOUT_CYC.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
rx_done_tick  in  1  one-cycle strobe from uart_rx; rx_data valid this cycle.
rx_data  in  8  received byte.
X_tank_pos  out  16  last validated X position.
Y_tank_pos  out  16  last validated Y position.
pos_valid  out  1  one-cycle pulse when X/Y update.
frame_err  out  1  one-cycle pulse on checksum failure or timeout.
err_count  out  8  saturating count of frame errors.
busy  out  1  high while a frame is in progress (state != HUNT).

Behaviour:
- One clock; reset is asynchronous, active-high.
- Frame format, in order: HEADER, XH, XL, YH, YL, CHK, where CHK = XH^XL^YH^YL.
- Reset values: all outputs 0; state HUNT; timer 0; shadow registers 0.
- States: HUNT, XH, XL, YH, YL, CHK.
  - HUNT: on rx_done_tick with rx_data==HEADER go to XH; other bytes are discarded silently, with no error.
  - XH, XL, YH, YL: on rx_done_tick store the byte in a shadow register, fold it into the running XOR, and advance.
  - CHK: on rx_done_tick, if rx_data == running XOR, load X_tank_pos={XH,XL} and Y_tank_pos={YH,YL} and pulse pos_valid. Otherwise pulse frame_err and increment err_count. Either way return to HUNT.
- Update latency: X/Y and pos_valid change on the clock edge that samples the CHK byte, so they are visible the cycle after rx_done_tick.
- X_tank_pos and Y_tank_pos change only together. They hold their value across failed and aborted frames.
- Bytes equal to HEADER arriving mid-frame are treated as data. There is no resync inside a frame.
- Running XOR clears when entering XH.
- Timeout:
  - The timer is cleared on every accepted rx_done_tick and held at 0 in HUNT.
  - Outside HUNT it increments every cycle.
  - When it reaches TIMEOUT_CYC-1 with no rx_done_tick that cycle, pulse frame_err, increment err_count, and go to HUNT. The byte that arrives later is parsed as a fresh HUNT byte.
- Simultaneous events: if rx_done_tick coincides with timer==TIMEOUT_CYC-1, the byte wins. It is accepted normally, the timer clears, and there is no error.
- err_count saturates at 8'hFF, with no wrap.
- frame_err and pos_valid are never high in the same cycle.
- Reset mid-frame: the frame is dropped and outputs return to 0 immediately (asynchronously).
- busy = (state != HUNT), registered with the state.

Decomposition:
- Shared package uart_pkg holds:
  - the HEADER constant (8'hA5);
  - the FRAME_LEN constant (6);
  - the state enum typedef (HUNT, XH, XL, YH, YL, CHK);
  - a checksum function, also used by the TX-side framer.
- One natural sub-module: uart_byte_timeout, a loadable counter. Inputs are clear and enable; the output is expire.

Test Plan:
1. Good frame: bytes A5 01 2C 00 C8, then CHK = 01^2C^00^C8 = E5 → pos_valid one cycle; X_tank_pos=16'h012C, Y_tank_pos=16'h00C8; frame_err=0.
2. Bad checksum: A5 01 2C 00 C8 00 → frame_err pulse; err_count=1; X/Y keep the previous values; no pos_valid.
3. Leading garbage: 3F 7E, then a good frame A5 00 10 00 20 30 → parsed correctly; err_count unchanged.
4. Timeout: A5 01, then idle for TIMEOUT_CYC cycles → frame_err at cycle TIMEOUT_CYC-1 after the 01 byte; busy drops. A following good frame is accepted.
5. Boundary race: deliver the next byte exactly at timer==TIMEOUT_CYC-1 → no error, frame completes. Separately, a payload containing A5 (A5 A5 00 00 01 A4) is accepted with X=16'hA500, Y=16'h0001.
6. Saturation and reset: 300 bad frames → err_count=FF. Assert reset in the middle of the YH byte → all outputs 0 at once. The next good frame parses correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART position link: framing constants, parser states
// and the frame checksum used by both the RX deframer and the TX framer.
package uart_pkg;

    localparam logic [7:0] HEADER    = 8'hA5;
    localparam int         FRAME_LEN = 6;

    typedef enum logic [$clog2(FRAME_LEN)-1:0] {
        HUNT,
        XH,
        XL,
        YH,
        YL,
        CHK
    } state_e;

    function automatic logic [7:0] pos_checksum(input logic [7:0] xh, input logic [7:0] xl,
                                                 input logic [7:0] yh, input logic [7:0] yl);
        return xh ^ xl ^ yh ^ yl;
    endfunction

endpackage

// File: rtl/uart_pos_deframer_if.sv
// Byte stream in from uart_rx and validated tank positions out to the game logic.
interface uart_pos_deframer_if;

    logic        rx_done_tick;
    logic [7:0]  rx_data;
    logic [15:0] X_tank_pos;
    logic [15:0] Y_tank_pos;
    logic        pos_valid;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    modport master (
        output rx_done_tick, rx_data,
        input  X_tank_pos, Y_tank_pos, pos_valid, frame_err, err_count, busy
    );

    modport slave (
        input  rx_done_tick, rx_data,
        output X_tank_pos, Y_tank_pos, pos_valid, frame_err, err_count, busy
    );

endinterface

// File: rtl/uart_byte_timeout.sv
// Inter-byte timer: counts while enabled, clears on demand, and flags expiry
// on the last allowed cycle unless a clear arrives in that same cycle.
module uart_byte_timeout #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int          TO_BIT      = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_BIT-1:0] TERM = TO_BIT'(TIMEOUT_CYC - 1);

    logic [TO_BIT-1:0] cnt_q;
    logic [TO_BIT-1:0] cnt_d;

    // A clear in the terminal cycle wins over expiry, so a late-but-in-time byte is kept.
    always_comb begin
        expire = enable && !clear && (cnt_q == TERM);
        cnt_d  = cnt_q + 1'b1;
        if (clear || expire || !enable) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_pos_deframer.sv
// Parses 6-byte tank-position frames (A5 XH XL YH YL CHK) from the uart_rx byte
// stream and publishes X/Y atomically once the XOR checksum matches.
module uart_pos_deframer
    import uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int          TO_BIT      = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_pos_deframer_if.slave   bus
);

    state_e      state_q, state_d;
    logic [7:0]  xh_q, xh_d;
    logic [7:0]  xl_q, xl_d;
    logic [7:0]  yh_q, yh_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        pos_valid_q, pos_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        busy_q, busy_d;

    logic        to_clear;
    logic        to_enable;
    logic        to_expire;
    logic        bad_frame;

    assign to_enable = (state_q != HUNT);
    assign to_clear  = bus.rx_done_tick || (state_q == HUNT);

    uart_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_BIT      (TO_BIT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (to_clear),
        .enable (to_enable),
        .expire (to_expire)
    );

    always_comb begin
        state_d     = state_q;
        xh_d        = xh_q;
        xl_d        = xl_q;
        yh_d        = yh_q;
        sum_d       = sum_q;
        x_d         = x_q;
        y_d         = y_q;
        pos_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_count_d = err_count_q;
        bad_frame   = 1'b0;

        case (state_q)
            HUNT: begin
                if (bus.rx_done_tick && (bus.rx_data == HEADER)) begin
                    state_d = XH;
                    sum_d   = '0;
                end
            end
            XH: begin
                if (bus.rx_done_tick) begin
                    xh_d    = bus.rx_data;
                    sum_d   = sum_q ^ bus.rx_data;
                    state_d = XL;
                end else begin
                    bad_frame = to_expire;
                end
            end
            XL: begin
                if (bus.rx_done_tick) begin
                    xl_d    = bus.rx_data;
                    sum_d   = sum_q ^ bus.rx_data;
                    state_d = YH;
                end else begin
                    bad_frame = to_expire;
                end
            end
            YH: begin
                if (bus.rx_done_tick) begin
                    yh_d    = bus.rx_data;
                    sum_d   = sum_q ^ bus.rx_data;
                    state_d = YL;
                end else begin
                    bad_frame = to_expire;
                end
            end
            YL: begin
                // YL is never stored: it is only needed for the Y update in CHK,
                // and it is recoverable there as sum ^ xh ^ xl ^ yh.
                if (bus.rx_done_tick) begin
                    sum_d   = sum_q ^ bus.rx_data;
                    state_d = CHK;
                end else begin
                    bad_frame = to_expire;
                end
            end
            CHK: begin
                if (bus.rx_done_tick) begin
                    state_d = HUNT;
                    if (bus.rx_data == sum_q) begin
                        x_d         = {xh_q, xl_q};
                        y_d         = {yh_q, sum_q ^ xh_q ^ xl_q ^ yh_q};
                        pos_valid_d = 1'b1;
                    end else begin
                        bad_frame = 1'b1;
                    end
                end else begin
                    bad_frame = to_expire;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (bad_frame) begin
            state_d     = HUNT;
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end

        busy_d = (state_d != HUNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            xh_q        <= '0;
            xl_q        <= '0;
            yh_q        <= '0;
            sum_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            pos_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            xh_q        <= xh_d;
            xl_q        <= xl_d;
            yh_q        <= yh_d;
            sum_q       <= sum_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pos_valid_q <= pos_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.X_tank_pos = x_q;
    assign bus.Y_tank_pos = y_q;
    assign bus.pos_valid  = pos_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_count  = err_count_q;
    assign bus.busy       = busy_q;

endmodule
